uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver: the consumer of the serial line driven by the team's `uart_tx` transmitter, in loopback benches and on the external RX pin.
- Frame format is 8N1, LSB first.
- Bit timing uses the same `cycles_per_bit` programming model as the transmitter, so one setting drives both directions.
- Received bytes go to the core through a one-entry valid/ready holding register, with framing-error and overrun flags.

Parameters:
- UART_SPEED_DEFAULT, 16'h186a, reset value of `cycles_per_bit`; bit period P = `cycles_per_bit` + 1 clocks.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial input; idle high
- data  input  16  new `cycles_per_bit` value, loaded when `set` is high
- set  input  1  load `cycles_per_bit` from `data`
- data_out  output  8  received byte; stable while `valid` is high
- valid  output  1  `data_out` holds an unconsumed byte
- ready  input  1  consumer accepts the byte on a cycle where `valid` && `ready`
- busy  output  1  high in any state other than IDLE
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `reset`; it has priority over everything.
- Reset values:
  - outputs: `data_out` = 0, `valid` = 0, `busy` = 0, `frame_err` = 0, `overrun` = 0
  - internal: `cycles_per_bit` = UART_SPEED_DEFAULT, state = IDLE, bit counter = 0, cycle counter = 0
  - synchronizer flops = 1
- Reset mid-frame discards the partial byte and any held byte.
- `rx` passes through a 2-flop synchronizer; `rx_s` is the second flop. All sampling uses `rx_s`. Let H = `cycles_per_bit` >> 1.
- `set` (priority below `reset`):
  - loads `cycles_per_bit` <= `data`;
  - if a frame is in progress, aborts it to IDLE with no flag;
  - does not affect `valid`, `data_out`, or the handshake.
- State machine (16-bit cycle counter, 3-bit bit counter):
  - IDLE: on `rx_s` = 0 while the previous `rx_s` = 1 (falling edge), clear the cycle counter and go to START.
  - START: when counter == H, sample `rx_s`.
    - If 0: go to DATA, clear counter and bit counter.
    - If 1: treat as a glitch and return to IDLE, no flag.
    - Otherwise increment the counter.
  - DATA: when counter == `cycles_per_bit`, shift `rx_s` into bit[bit counter] (LSB first) and clear the counter.
    - After bit 7 go to STOP; otherwise increment the bit counter.
    - Otherwise increment the counter.
  - STOP: when counter == `cycles_per_bit`, sample `rx_s` (mid stop bit) and go to IDLE.
    - If 1: deliver the byte.
    - If 0: pulse `frame_err` for one cycle and discard the byte.
  - After a framing error, a new frame is recognised only on a fresh 1->0 edge of `rx_s`.
- Delivery (the cycle after the STOP sample):
  - If `valid` = 0, or `valid` && `ready` on that same cycle: load `data_out`, set `valid` = 1. No overrun.
  - Else: pulse `overrun` for one cycle, drop the new byte, and keep the old `data_out`.
- Handshake: `valid` falls the cycle after `valid` && `ready`, unless a delivery reloads it on that cycle. `data_out` must not change while `valid` = 1 and `ready` = 0.
- Latency: `valid` rises 9*P + H + 3 clocks (±1) after the `rx` pin falls at start of frame.
- Edge cases:
  - `cycles_per_bit` = 0: P = 1, H = 0; legal, and the receiver must not lock up.
  - Counters never wrap within a bit because compare happens before increment.
- Back-to-back frames: a start edge immediately after the stop-bit sample is accepted. The receiver returns to IDLE at mid-stop, so it tolerates a transmitter that is up to half a bit fast.

Test Plan:
- Default speed, `ready` = 1, 0xA5 then 0x3C sent back-to-back by a `uart_tx` instance (same `cycles_per_bit`) -> two `valid` pulses with `data_out` = 0xA5, 0x3C; `frame_err` and `overrun` stay 0.
- `set` with `data` = 15 (P = 16, H = 7), bit-banged 0x55 -> `valid` rises 154±1 clocks after the start edge, `data_out` = 0x55, `busy` high throughout the frame.
- `rx` low for 3 clocks then high, with `cycles_per_bit` = 15 -> return to IDLE by mid-start; no `valid`, no `frame_err`.
- Frame 0x81 with stop bit driven 0 -> one-cycle `frame_err`, `valid` stays 0; next good frame 0x42 received correctly.
- `ready` = 0, frames 0x11 then 0x22 -> `data_out` = 0x11 held; `overrun` pulses once at the 0x22 delivery; after `ready` is raised, `valid` drops and 0x11 is the only byte seen.
- Reset asserted at bit 4 of 0xF0 -> all outputs 0, `busy` = 0 next cycle; following frame 0x0F received. Separately, `set` mid-frame -> frame aborted silently, new rate used on the next frame.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, with a programmable bit period and a one-entry
// valid/ready holding register that reports framing errors and overruns.
module uart_rx #(
  parameter logic [15:0] UART_SPEED_DEFAULT = 16'h186a
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [15:0] data,
  input  logic        set,
  output logic [7:0]  data_out,
  output logic        valid,
  input  logic        ready,
  output logic        busy,
  output logic        frame_err,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e      state_q, state_d;
  logic        rxMeta_q, rxSync_q, rxPrev_q;
  logic [15:0] cyclesPerBit_q, cyclesPerBit_d;
  logic [15:0] cycleCnt_q, cycleCnt_d;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  dataOut_q, dataOut_d;
  logic        valid_q, valid_d;
  logic        frameErr_q, frameErr_d;
  logic        overrun_q, overrun_d;
  logic [15:0] halfBit;

  assign halfBit = cyclesPerBit_q >> 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxMeta_q       <= 1'b1;
      rxSync_q       <= 1'b1;
      rxPrev_q       <= 1'b1;
      state_q        <= IDLE;
      cyclesPerBit_q <= UART_SPEED_DEFAULT;
      cycleCnt_q     <= 16'd0;
      bitCnt_q       <= 3'd0;
      shift_q        <= 8'd0;
      dataOut_q      <= 8'd0;
      valid_q        <= 1'b0;
      frameErr_q     <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      rxMeta_q       <= rx;
      rxSync_q       <= rxMeta_q;
      rxPrev_q       <= rxSync_q;
      state_q        <= state_d;
      cyclesPerBit_q <= cyclesPerBit_d;
      cycleCnt_q     <= cycleCnt_d;
      bitCnt_q       <= bitCnt_d;
      shift_q        <= shift_d;
      dataOut_q      <= dataOut_d;
      valid_q        <= valid_d;
      frameErr_q     <= frameErr_d;
      overrun_q      <= overrun_d;
    end
  end

  // Delivery happens on the mid-stop sample itself, so a consumer taking the
  // old byte on that same cycle frees the register for the new one.
  always_comb begin
    state_d        = state_q;
    cyclesPerBit_d = cyclesPerBit_q;
    cycleCnt_d     = cycleCnt_q;
    bitCnt_d       = bitCnt_q;
    shift_d        = shift_q;
    dataOut_d      = dataOut_q;
    valid_d        = valid_q && !ready;
    frameErr_d     = 1'b0;
    overrun_d      = 1'b0;

    if (set) begin
      cyclesPerBit_d = data;
      state_d        = IDLE;
      cycleCnt_d     = 16'd0;
      bitCnt_d       = 3'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!rxSync_q && rxPrev_q) begin
            state_d    = START;
            cycleCnt_d = 16'd0;
          end
        end
        START: begin
          if (cycleCnt_q == halfBit) begin
            cycleCnt_d = 16'd0;
            bitCnt_d   = 3'd0;
            state_d    = rxSync_q ? IDLE : DATA;
          end else begin
            cycleCnt_d = cycleCnt_q + 16'd1;
          end
        end
        DATA: begin
          if (cycleCnt_q == cyclesPerBit_q) begin
            shift_d[bitCnt_q] = rxSync_q;
            cycleCnt_d        = 16'd0;
            if (bitCnt_q == 3'd7) begin
              state_d = STOP;
            end else begin
              bitCnt_d = bitCnt_q + 3'd1;
            end
          end else begin
            cycleCnt_d = cycleCnt_q + 16'd1;
          end
        end
        STOP: begin
          if (cycleCnt_q == cyclesPerBit_q) begin
            state_d    = IDLE;
            cycleCnt_d = 16'd0;
            if (!rxSync_q) begin
              frameErr_d = 1'b1;
            end else if (!valid_q || ready) begin
              dataOut_d = shift_q;
              valid_d   = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            cycleCnt_d = cycleCnt_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    data_out  = dataOut_q;
    valid     = valid_q;
    frame_err = frameErr_q;
    overrun   = overrun_q;
  end

endmodule
